// File: rtl/experiment5_store_sequencer.sv
// Copies a run of register-file entries into consecutive RAM words, reading each
// word back to verify it and accumulating a checksum of everything written.
module experiment5_store_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 6
) (
    input  logic                clk_m,
    input  logic                Reset,
    input  logic                Start,
    input  logic [REG_AW-1:0]   Reg_Start_Addr,
    input  logic [MEM_AW+1:0]   Mem_Start_Addr,
    input  logic [5:0]          Count,
    output logic [REG_AW-1:0]   R_Addr_B,
    input  logic [DATA_W-1:0]   R_Data_B,
    output logic [MEM_AW+1:0]   Mem_Addr,
    output logic                Mem_Write,
    output logic [DATA_W-1:0]   Write_Data,
    input  logic [DATA_W-1:0]   Read_Data,
    output logic                Busy,
    output logic                Done,
    output logic                Mismatch,
    output logic [MEM_AW+1:0]   Fail_Addr,
    output logic [DATA_W-1:0]   Checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_reg;
    logic [REG_AW-1:0]   reg_ptr_reg;
    logic [MEM_AW-1:0]   mem_ptr_reg;
    logic [5:0]          remaining_reg;
    logic [DATA_W-1:0]   data_q_reg;
    logic [DATA_W-1:0]   checksum_reg;
    logic                mismatch_reg;
    logic [MEM_AW+1:0]   fail_addr_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                mem_write_reg;

    always_ff @(posedge clk_m) begin
        if (Reset) begin
            state_reg     <= IDLE;
            reg_ptr_reg   <= '0;
            mem_ptr_reg   <= '0;
            remaining_reg <= '0;
            data_q_reg    <= '0;
            checksum_reg  <= '0;
            mismatch_reg  <= 1'b0;
            fail_addr_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            mem_write_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        mismatch_reg  <= 1'b0;
                        fail_addr_reg <= '0;
                        checksum_reg  <= '0;
                        busy_reg      <= 1'b1;
                        if (Count != 6'd0) begin
                            reg_ptr_reg   <= Reg_Start_Addr;
                            mem_ptr_reg   <= Mem_Start_Addr[MEM_AW+1:2];
                            remaining_reg <= Count;
                            state_reg     <= LOAD;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                LOAD: begin
                    data_q_reg    <= R_Data_B;
                    mem_write_reg <= 1'b1;
                    state_reg     <= WRITE;
                end
                WRITE: begin
                    checksum_reg <= checksum_reg + data_q_reg;
                    state_reg    <= READ;
                end
                READ: begin
                    state_reg <= CMP;
                end
                CMP: begin
                    // Read_Data now reflects the address held through WRITE and READ
                    if ((Read_Data != data_q_reg) && !mismatch_reg) begin
                        mismatch_reg  <= 1'b1;
                        fail_addr_reg <= {mem_ptr_reg, 2'b00};
                    end
                    reg_ptr_reg   <= reg_ptr_reg + REG_AW'(1);
                    mem_ptr_reg   <= mem_ptr_reg + MEM_AW'(1);
                    remaining_reg <= remaining_reg - 6'd1;
                    if (remaining_reg == 6'd1) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= LOAD;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign R_Addr_B   = reg_ptr_reg;
    assign Mem_Addr   = {mem_ptr_reg, 2'b00};
    assign Mem_Write  = mem_write_reg;
    assign Write_Data = data_q_reg;
    assign Busy       = busy_reg;
    assign Done       = done_reg;
    assign Mismatch   = mismatch_reg;
    assign Fail_Addr  = fail_addr_reg;
    assign Checksum   = checksum_reg;

endmodule

// File: tb/tb_experiment5_store_sequencer.sv
// Bench for the store sequencer: register file and RAM models, a transfer-level
// expectation model checked every cycle, and directed scenarios with literal results.
module tb_experiment5_store_sequencer;

    logic        clk_m = 1'b0;
    logic        Reset;
    logic        Start;
    logic [4:0]  Reg_Start_Addr;
    logic [7:0]  Mem_Start_Addr;
    logic [5:0]  Count;
    logic [4:0]  R_Addr_B;
    logic [31:0] R_Data_B;
    logic [7:0]  Mem_Addr;
    logic        Mem_Write;
    logic [31:0] Write_Data;
    logic [31:0] Read_Data;
    logic        Busy;
    logic        Done;
    logic        Mismatch;
    logic [7:0]  Fail_Addr;
    logic [31:0] Checksum;

    experiment5_store_sequencer #(.DATA_W(32), .REG_AW(5), .MEM_AW(6)) dut (
        .clk_m(clk_m), .Reset(Reset), .Start(Start),
        .Reg_Start_Addr(Reg_Start_Addr), .Mem_Start_Addr(Mem_Start_Addr), .Count(Count),
        .R_Addr_B(R_Addr_B), .R_Data_B(R_Data_B),
        .Mem_Addr(Mem_Addr), .Mem_Write(Mem_Write), .Write_Data(Write_Data),
        .Read_Data(Read_Data), .Busy(Busy), .Done(Done), .Mismatch(Mismatch),
        .Fail_Addr(Fail_Addr), .Checksum(Checksum)
    );

    always #5 clk_m = ~clk_m;

    int cyc = 0;
    always @(posedge clk_m) cyc <= cyc + 1;

    // Register file (combinational read) and RAM (read-first, 1-cycle read latency)
    logic [31:0] regs [32];
    logic [31:0] ram  [64];
    logic        corrupt_en = 1'b0;
    int          corrupt_idx = 0;
    assign R_Data_B = regs[R_Addr_B];

    always @(posedge clk_m) begin
        if (Mem_Write) begin
            if (corrupt_en && int'(Mem_Addr[7:2]) == corrupt_idx)
                ram[Mem_Addr[7:2]] <= Write_Data | 32'h1;
            else
                ram[Mem_Addr[7:2]] <= Write_Data;
        end
        Read_Data <= ram[Mem_Addr[7:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transfer-level model: last accepted start edge and its parameters, last reset edge
    int          st_edge = 0;
    int          rst_edge = 1;
    int          mn = 0;
    int          mr0 = 0;
    int          mm0 = 0;
    int          exp_bad = -1;
    logic [31:0] md [64];
    bit          chk_on = 1'b0;
    bit          done_seen = 1'b0;
    int          done_off = 0;
    logic [7:0]  wlog_addr [$];
    logic [4:0]  wlog_reg [$];

    always @(negedge clk_m) begin
        int j, i, iw;
        logic [31:0] sum;
        if (chk_on) begin
            chk("addr_lsbs", 32'(Mem_Addr[1:0]), 32'd0);
            if (Mem_Write) begin
                wlog_addr.push_back(Mem_Addr);
                wlog_reg.push_back(R_Addr_B);
            end
            if (Done) begin
                done_seen = 1'b1;
                done_off  = cyc - st_edge + 1;
            end
            if (rst_edge > st_edge && cyc >= rst_edge) begin
                chk("rst_busy", 32'(Busy), 32'd0);
                chk("rst_done", 32'(Done), 32'd0);
                chk("rst_mem_write", 32'(Mem_Write), 32'd0);
                chk("rst_mismatch", 32'(Mismatch), 32'd0);
                chk("rst_fail_addr", 32'(Fail_Addr), 32'd0);
                chk("rst_checksum", Checksum, 32'd0);
                chk("rst_mem_addr", 32'(Mem_Addr), 32'd0);
                chk("rst_r_addr", 32'(R_Addr_B), 32'd0);
                chk("rst_write_data", Write_Data, 32'd0);
            end else if (cyc >= st_edge) begin
                j = cyc - st_edge;
                chk("busy", 32'(Busy), 32'(j <= 4 * mn));
                chk("done", 32'(Done), 32'(j == 4 * mn));
                chk("mem_write", 32'(Mem_Write), 32'(mn > 0 && j < 4 * mn && j % 4 == 1));
                sum = 32'd0;
                for (int k = 0; k < mn; k++)
                    if (4 * k + 2 <= j) sum = sum + md[k];
                chk("checksum", Checksum, sum);
                if (exp_bad >= 0 && 4 * exp_bad + 4 <= j) begin
                    chk("mismatch", 32'(Mismatch), 32'd1);
                    chk("fail_addr", 32'(Fail_Addr), 32'(((mm0 + exp_bad) % 64) * 4));
                end else begin
                    chk("mismatch", 32'(Mismatch), 32'd0);
                    chk("fail_addr", 32'(Fail_Addr), 32'd0);
                end
                if (mn > 0) begin
                    i = (j < 4 * mn) ? j / 4 : mn;
                    chk("r_addr", 32'(R_Addr_B), 32'((mr0 + i) % 32));
                    chk("mem_addr", 32'(Mem_Addr), 32'(((mm0 + i) % 64) * 4));
                    if (j >= 1) begin
                        iw = (j - 1) / 4;
                        if (iw > mn - 1) iw = mn - 1;
                        chk("write_data", Write_Data, md[iw]);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_m);
            #2;
        end
    endtask

    // Pulse Start for one edge and record the expected transfer in the model
    task automatic go(input logic [4:0] r, input logic [7:0] m, input logic [5:0] n);
        Reg_Start_Addr = r;
        Mem_Start_Addr = m;
        Count          = n;
        Start          = 1'b1;
        mn  = int'(n);
        mr0 = int'(r);
        mm0 = int'(m[7:2]);
        exp_bad = -1;
        for (int i = 0; i < mn; i++) begin
            md[i] = regs[(mr0 + i) % 32];
            if (exp_bad < 0 && corrupt_en && ((mm0 + i) % 64) == corrupt_idx && md[i][0] == 1'b0)
                exp_bad = i;
        end
        done_seen = 1'b0;
        wlog_addr.delete();
        wlog_reg.delete();
        st_edge = cyc + 1;
        step(1);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done_seen && c < budget) begin
            step(1);
            c++;
        end
        chk("done_within_budget", 32'(done_seen), 32'd1);
        step(2);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Reg_Start_Addr = '0;
        Mem_Start_Addr = '0;
        Count = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hC000_0000 | 32'(i);
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        regs[0]  = 32'h0000_0100;
        regs[2]  = 32'hAAAA_AAAA;
        regs[3]  = 32'h5555_5555;
        regs[4]  = 32'h0000_0001;
        regs[8]  = 32'h0000_0010;
        regs[9]  = 32'h0000_0022;
        regs[10] = 32'h0000_0030;
        regs[11] = 32'h0000_0044;
        regs[30] = 32'h3030_3030;
        regs[31] = 32'h3131_3131;
        step(2);
        Reset  = 1'b0;
        chk_on = 1'b1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_checksum", Checksum, 32'd0);
        step(2);

        // Three words from r2 to byte 0x10; the values sum to zero mod 2^32
        go(5'd2, 8'h10, 6'd3);
        wait_done(60);
        chk("t1_done_latency", 32'(done_off), 32'd13);
        chk("t1_checksum", Checksum, 32'h0000_0000);
        chk("t1_mismatch", 32'(Mismatch), 32'd0);
        chk("t1_nwrites", 32'(wlog_addr.size()), 32'd3);
        chk("t1_addr0", 32'(wlog_addr[0]), 32'h10);
        chk("t1_addr1", 32'(wlog_addr[1]), 32'h14);
        chk("t1_addr2", 32'(wlog_addr[2]), 32'h18);
        chk("t1_ram4", ram[4], 32'hAAAA_AAAA);
        chk("t1_ram5", ram[5], 32'h5555_5555);
        chk("t1_ram6", ram[6], 32'h0000_0001);

        go(5'd7, 8'h20, 6'd0);
        wait_done(10);
        chk("t2_done_latency", 32'(done_off), 32'd1);
        chk("t2_nwrites", 32'(wlog_addr.size()), 32'd0);
        chk("t2_checksum", Checksum, 32'd0);

        // Both pointers wrap
        go(5'd30, 8'hFC, 6'd3);
        wait_done(60);
        chk("t3_reg0", 32'(wlog_reg[0]), 32'd30);
        chk("t3_reg1", 32'(wlog_reg[1]), 32'd31);
        chk("t3_reg2", 32'(wlog_reg[2]), 32'd0);
        chk("t3_addr0", 32'(wlog_addr[0]), 32'hFC);
        chk("t3_addr1", 32'(wlog_addr[1]), 32'h00);
        chk("t3_addr2", 32'(wlog_addr[2]), 32'h04);
        chk("t3_checksum", Checksum, 32'h6161_6261);

        // RAM corrupts word 5 (byte 0x14)
        corrupt_en  = 1'b1;
        corrupt_idx = 5;
        go(5'd8, 8'h10, 6'd4);
        wait_done(80);
        corrupt_en = 1'b0;
        chk("t4_done_latency", 32'(done_off), 32'd17);
        chk("t4_mismatch", 32'(Mismatch), 32'd1);
        chk("t4_fail_addr", 32'(Fail_Addr), 32'h14);
        chk("t4_checksum", Checksum, 32'h0000_00A6);
        chk("t4_nwrites", 32'(wlog_addr.size()), 32'd4);
        step(3);
        chk("t4_hold_mismatch", 32'(Mismatch), 32'd1);

        // A second Start mid-transfer must be ignored
        go(5'd2, 8'h40, 6'd3);
        step(4);
        Reg_Start_Addr = 5'd20;
        Mem_Start_Addr = 8'h80;
        Count = 6'd5;
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        wait_done(60);
        chk("t5_done_latency", 32'(done_off), 32'd13);
        chk("t5_nwrites", 32'(wlog_addr.size()), 32'd3);
        chk("t5_addr2", 32'(wlog_addr[2]), 32'h48);
        chk("t5_ram18", ram[18], 32'h0000_0001);

        // Reset during the WRITE cycle of word 1 (offset 5 after the start edge)
        go(5'd2, 8'h20, 6'd3);
        step(5);
        chk("t6_write_before_reset", 32'(Mem_Write), 32'd1);
        Reset = 1'b1;
        rst_edge = cyc + 1;
        step(1);
        Reset = 1'b0;
        chk("t6_mem_write_after_reset", 32'(Mem_Write), 32'd0);
        chk("t6_busy_after_reset", 32'(Busy), 32'd0);
        step(12);
        chk("t6_no_done", 32'(done_seen), 32'd0);

        // Byte-address low bits are ignored
        go(5'd0, 8'h13, 6'd2);
        wait_done(40);
        chk("t7_addr0", 32'(wlog_addr[0]), 32'h10);
        chk("t7_addr1", 32'(wlog_addr[1]), 32'h14);
        chk("t7_ram4", ram[4], 32'h0000_0100);
        chk("t7_checksum", Checksum, 32'hC000_0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
